// File: rtl/gpio_pulse_pkg.sv
// rtl/gpio_pulse_pkg.sv - shared constants and types for the GPIO pulse transmitter
//
// Register map addresses, CONTROL/STATUS bit positions and the FSM state type.
package gpio_pulse_pkg;

  localparam logic [2:0] PATTERN_ADDR = 3'd0;
  localparam logic [2:0] LENGTH_ADDR  = 3'd1;
  localparam logic [2:0] DIVIDER_ADDR = 3'd2;
  localparam logic [2:0] CONTROL_ADDR = 3'd3;
  localparam logic [2:0] STATUS_ADDR  = 3'd4;

  localparam int CTRL_START_BIT      = 0;
  localparam int CTRL_REPEAT_BIT     = 1;
  localparam int CTRL_IRQ_EN_BIT     = 2;
  localparam int CTRL_IDLE_LEVEL_BIT = 3;
  localparam int CTRL_STOP_BIT       = 4;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/gpio_pulse_divider.sv
// rtl/gpio_pulse_divider.sv - bit-period tick counter for the pulse transmitter
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        sample divider_i into the period shadow and restart the count
//   enable_i      count while high (transmitter is shifting)
//   divider_i     cycles per bit; 0 behaves as 1
//   tick_o        high on the last cycle of each bit period
module gpio_pulse_divider
  import gpio_pulse_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q;
  // Terminal count (period - 1) captured at load so CPU writes mid-burst
  // do not disturb the bit currently being sent.
  logic [DIV_WIDTH-1:0] limit_q;

  assign tick_o = enable_i && (count_q == limit_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      limit_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
      limit_q <= (divider_i == '0) ? '0 : divider_i - DIV_WIDTH'(1);
    end else if (enable_i) begin
      count_q <= tick_o ? '0 : count_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gpio_pulse_tx.sv
// rtl/gpio_pulse_tx.sv - single-pin serial pattern transmitter with register interface
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   write_i          one-cycle register write strobe
//   write_address_i  register select for writes
//   write_data_i     write data
//   read_address_i   register select for reads
//   read_data_o      combinational read data
//   pin_o            registered pin drive, pattern shifted out LSB-first
//   busy_o           high while shifting
//   interrupt_o      done & irq_enable
module gpio_pulse_tx
  import gpio_pulse_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_i,
  input  logic [2:0]            write_address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [2:0]            read_address_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  pin_o,
  output logic                  busy_o,
  output logic                  interrupt_o
);

  localparam int LW = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] LEN_MAX = DATA_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] pattern_q;
  logic [LW-1:0]         length_q;
  logic [DIV_WIDTH-1:0]  divider_q;
  logic                  repeat_q, irq_en_q, idle_level_q;

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [LW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic                  pin_q, pin_d;

  logic ctrl_wr, start_req, stop_req, status_clr, idle_level_d;
  logic div_load, tick, start_ok, burst_end;

  assign ctrl_wr      = write_i && (write_address_i == CONTROL_ADDR);
  assign start_req    = ctrl_wr && write_data_i[CTRL_START_BIT];
  assign stop_req     = ctrl_wr && write_data_i[CTRL_STOP_BIT];
  assign status_clr   = write_i && (write_address_i == STATUS_ADDR) && write_data_i[STATUS_DONE_BIT];
  assign idle_level_d = ctrl_wr ? write_data_i[CTRL_IDLE_LEVEL_BIT] : idle_level_q;

  gpio_pulse_divider #(.DIV_WIDTH(DIV_WIDTH)) u_divider (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (div_load),
    .enable_i  (state_q == SHIFT),
    .divider_i (divider_q),
    .tick_o    (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pattern_q    <= '0;
      length_q     <= '0;
      divider_q    <= DIV_WIDTH'(1);
      repeat_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      idle_level_q <= 1'b0;
    end else if (write_i) begin
      case (write_address_i)
        PATTERN_ADDR: pattern_q <= write_data_i;
        LENGTH_ADDR:  length_q  <= (write_data_i > LEN_MAX) ? LW'(DATA_WIDTH) : write_data_i[LW-1:0];
        DIVIDER_ADDR: divider_q <= write_data_i[DIV_WIDTH-1:0];
        CONTROL_ADDR: begin
          repeat_q     <= write_data_i[CTRL_REPEAT_BIT];
          irq_en_q     <= write_data_i[CTRL_IRQ_EN_BIT];
          idle_level_q <= write_data_i[CTRL_IDLE_LEVEL_BIT];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      pin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      pin_q     <= pin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_load  = 1'b0;
    start_ok  = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req && !stop_req && (length_q != '0)) begin
          start_ok  = 1'b1;
          state_d   = SHIFT;
          shift_d   = pattern_q;
          bit_cnt_d = length_q - LW'(1);
          div_load  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - LW'(1);
          end else if (repeat_q && (length_q != '0)) begin
            // Back-to-back reload; a LENGTH of 0 written mid-burst ends it instead.
            shift_d   = pattern_q;
            bit_cnt_d = length_q - LW'(1);
            div_load  = 1'b1;
          end else begin
            state_d   = IDLE;
            burst_end = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop_req) begin
      state_d   = IDLE;
      burst_end = 1'b0;
      div_load  = 1'b0;
    end

    // Completion outranks a same-cycle write-1-to-clear.
    done_d = done_q;
    if (status_clr) done_d = 1'b0;
    if (start_ok)   done_d = 1'b0;
    if (burst_end)  done_d = 1'b1;

    pin_d = (state_d == SHIFT) ? shift_d[0] : idle_level_d;
  end

  always_comb begin
    read_data_o = '0;
    case (read_address_i)
      PATTERN_ADDR: read_data_o = pattern_q;
      LENGTH_ADDR:  read_data_o = DATA_WIDTH'(length_q);
      DIVIDER_ADDR: read_data_o = DATA_WIDTH'(divider_q);
      CONTROL_ADDR: begin
        read_data_o[CTRL_REPEAT_BIT]     = repeat_q;
        read_data_o[CTRL_IRQ_EN_BIT]     = irq_en_q;
        read_data_o[CTRL_IDLE_LEVEL_BIT] = idle_level_q;
      end
      STATUS_ADDR: begin
        read_data_o[STATUS_BUSY_BIT] = (state_q == SHIFT);
        read_data_o[STATUS_DONE_BIT] = done_q;
      end
      default: read_data_o = '0;
    endcase
  end

  assign pin_o       = pin_q;
  assign busy_o      = (state_q == SHIFT);
  assign interrupt_o = done_q & irq_en_q;

endmodule

// File: tb/tb_gpio_pulse_tx.sv
// tb/tb_gpio_pulse_tx.sv - self-checking bench for gpio_pulse_tx
`timescale 1ns/1ps
module tb_gpio_pulse_tx;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_i = 1'b0;
  logic [2:0]    write_address = '0;
  logic [DW-1:0] write_data = '0;
  logic [2:0]    read_address = '0;
  logic [DW-1:0] read_data;
  logic          pin, busy, irq;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gpio_pulse_tx #(.DATA_WIDTH(DW), .DIV_WIDTH(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .write_i         (write_i),
    .write_address_i (write_address),
    .write_data_i    (write_data),
    .read_address_i  (read_address),
    .read_data_o     (read_data),
    .pin_o           (pin),
    .busy_o          (busy),
    .interrupt_o     (irq)
  );

  // Reference model: a burst is a queue of per-cycle pin values.
  logic [31:0] m_pat;
  logic [31:0] m_len;
  logic [15:0] m_div;
  bit m_rep, m_irq, m_idle, m_busy, m_done, m_pin;
  bit q[$];

  bit seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit seq_rep [3] = '{1, 1, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pat = 0; m_len = 0; m_div = 16'd1;
    m_rep = 0; m_irq = 0; m_idle = 0;
    m_busy = 0; m_done = 0; m_pin = 0;
    q.delete();
  endtask

  task automatic m_gen();
    int per;
    per = (m_div == 0) ? 1 : int'(m_div);
    for (int i = 0; i < int'(m_len); i++)
      for (int j = 0; j < per; j++) q.push_back(m_pat[i]);
  endtask

  task automatic m_step();
    bit stp, sta, clr, ends, sok;
    stp  = write_i && write_address == 3'd3 && write_data[4];
    sta  = write_i && write_address == 3'd3 && write_data[0];
    clr  = write_i && write_address == 3'd4 && write_data[1];
    ends = 0;
    sok  = !m_busy && sta && !stp && (m_len != 0);
    if (m_busy) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (m_rep) m_gen();
        if (q.size() == 0) ends = 1;
      end
    end
    if (stp) begin
      m_busy = 0; q.delete(); ends = 0;
    end else if (ends) begin
      m_busy = 0;
    end
    if (clr) m_done = 0;
    if (sok) begin
      m_done = 0; m_busy = 1; m_gen();
    end
    if (ends) m_done = 1;
    if (write_i) begin
      case (write_address)
        3'd0: m_pat = write_data;
        3'd1: m_len = (write_data > 32) ? 32 : write_data;
        3'd2: m_div = write_data[15:0];
        3'd3: begin
          m_rep = write_data[1]; m_irq = write_data[2]; m_idle = write_data[3];
        end
        default: ;
      endcase
    end
    m_pin = m_busy ? q[0] : m_idle;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_pat;
      3'd1: return m_len;
      3'd2: return 32'(m_div);
      3'd3: return 32'({m_idle, m_irq, m_rep, 1'b0});
      3'd4: return 32'({m_done, m_busy});
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pin", 32'(pin), 32'(m_pin));
      check("busy", 32'(busy), 32'(m_busy));
      check("irq", 32'(irq), 32'(m_done & m_irq));
      check("rdata", read_data, m_read(read_address));
    end
  end

  task automatic drive(input logic w, input logic [2:0] a, input logic [31:0] d);
    write_i = w; write_address = a; write_data = d;
    read_address = 3'($urandom_range(0, 7));
    @(negedge clk); #1;
    write_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 3'd0, 32'd0);
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [31:0] exp);
    read_address = a;
    #0.25;
    check(name, read_data, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] a;
    logic [31:0] d;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    check("reset_pin", 32'(pin), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) peek("reset_rd", 3'(i), (i == 2) ? 32'd1 : 32'd0);

    // Start with LENGTH = 0 is ignored.
    drive(1, 3'd3, 32'h1);
    check("len0_busy", 32'(busy), 32'd0);

    // Basic burst.
    drive(1, 3'd0, 32'hA5); drive(1, 3'd1, 32'd8); drive(1, 3'd2, 32'd4);
    drive(1, 3'd3, 32'h5);
    for (int k = 0; k < 32; k++) begin
      check("basic_pin", 32'(pin), 32'(seq_a5[k / 4]));
      check("basic_busy", 32'(busy), 32'd1);
      idle(1);
    end
    check("basic_end_pin", 32'(pin), 32'd0);
    check("basic_end_busy", 32'(busy), 32'd0);
    check("basic_irq", 32'(irq), 32'd1);

    // Done clear racing the final terminal cycle.
    drive(1, 3'd0, 32'h3); drive(1, 3'd1, 32'd2); drive(1, 3'd2, 32'd1);
    drive(1, 3'd3, 32'h5);
    idle(1);
    drive(1, 3'd4, 32'h2);
    check("race_irq", 32'(irq), 32'd1);
    check("race_busy", 32'(busy), 32'd0);
    idle(2);
    drive(1, 3'd4, 32'h2);
    check("clear_irq", 32'(irq), 32'd0);

    // Divider 0 with repeat.
    drive(1, 3'd0, 32'h3); drive(1, 3'd1, 32'd3); drive(1, 3'd2, 32'd0);
    drive(1, 3'd3, 32'h7);
    for (int k = 0; k < 9; k++) begin
      check("rep_pin", 32'(pin), 32'(seq_rep[k % 3]));
      check("rep_irq", 32'(irq), 32'd0);
      idle(1);
    end
    drive(1, 3'd3, 32'h10);
    check("rep_stop_busy", 32'(busy), 32'd0);

    // Abort at cycle 10 with idle_level = 1.
    drive(1, 3'd0, $urandom); drive(1, 3'd1, 32'd8); drive(1, 3'd2, 32'd4);
    drive(1, 3'd3, 32'hD);
    idle(9);
    drive(1, 3'd3, 32'h1C);
    check("abort_pin", 32'(pin), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_irq", 32'(irq), 32'd0);
    peek("abort_status", 3'd4, 32'd0);
    drive(1, 3'd3, 32'h0);

    // Start while busy leaves the burst unchanged.
    drive(1, 3'd0, 32'hF0); drive(1, 3'd1, 32'd8); drive(1, 3'd2, 32'd1);
    drive(1, 3'd3, 32'h1);
    idle(2);
    drive(1, 3'd0, 32'h0F);
    drive(1, 3'd3, 32'h1);
    check("restart_pin", 32'(pin), 32'd1);
    n = 0;
    while (busy && n < 20) begin n++; idle(1); end
    check("restart_len", 32'(n), 32'd4);

    // LENGTH above DATA_WIDTH clamps.
    drive(1, 3'd1, 32'd37);
    peek("clamp_rd", 3'd1, 32'd32);
    drive(1, 3'd0, $urandom); drive(1, 3'd2, 32'd0);
    drive(1, 3'd3, 32'h1);
    n = 0;
    while (busy && n < 100) begin n++; idle(1); end
    check("clamp_len", 32'(n), 32'd32);

    // Asynchronous reset mid-burst.
    drive(1, 3'd0, 32'hFF); drive(1, 3'd1, 32'd8); drive(1, 3'd2, 32'd2);
    drive(1, 3'd3, 32'h5);
    idle(3);
    check("pre_rst_pin", 32'(pin), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #0.5;
    check("rst_pin", 32'(pin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) peek("rst_rd", 3'(i), (i == 2) ? 32'd1 : 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model.
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) begin
        a = 3'($urandom_range(0, 7));
        case (a)
          3'd1: d = $urandom_range(0, 40);
          3'd2: d = $urandom_range(0, 3);
          3'd3: begin
            d = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) d[4] = 1'b1;
          end
          3'd4: d = $urandom_range(0, 3);
          default: d = $urandom;
        endcase
        drive(1, a, d);
      end else begin
        idle(1);
      end
    end
    drive(1, 3'd3, 32'h10);
    idle(2);
    check("final_busy", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
